// File: rtl/gnw_pkg.sv
// Shared types and constants for the G&W ROM loader.
package gnw_pkg;
  localparam int ADDR_W = 25;

  localparam logic [1:0] WTBT_LO   = 2'b01;
  localparam logic [1:0] WTBT_HI   = 2'b10;
  localparam logic [1:0] WTBT_BOTH = 2'b11;

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, WAIT_RDY, FLUSH, DONE} gnw_ldr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       din;
    logic [1:0]        wtbt;
  } gnw_mem_req_t;

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction
endpackage

// File: rtl/gnw_cksum16.sv
// 16-bit wrapping byte accumulator for the loaded ROM image.
module gnw_cksum16 (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] sum
);
  always_ff @(posedge clk_sys) begin
    if (reset || clr) sum <= '0;
    else if (en)      sum <= sum + {8'h00, data};
  end
endmodule

// File: rtl/gnw_rom_loader.sv
// Packs hps_io ioctl bytes into 16-bit SDRAM writes, tracks image size and load completion.
// Define GNW_LOADER_CHECKSUM_EN to add the cksum output (byte sum of the image).
module gnw_rom_loader
  import gnw_pkg::*;
#(
  parameter logic [7:0]        ROM_INDEX = 8'd0,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_wtbt,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] rom_size,
  output logic              loaded
`ifdef GNW_LOADER_CHECKSUM_EN
  , output logic [15:0]     cksum
`endif
);
  gnw_ldr_state_t    state, state_nx;
  gnw_mem_req_t      req, req_nx, q_req, q_req_nx, flush_req;
  logic              pend, pend_nx, q_vld, q_vld_nx, fin, fin_nx, dl_q;
  logic [7:0]        pend_byte, pend_byte_nx;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nx, rom_size_nx;
  logic              loaded_nx, mem_we_nx, wait_nx;

  logic              dl_ours, acc, rise, fall, ending, odd;
  logic [ADDR_W-1:0] byte_addr, word, addr_p1;

  assign dl_ours   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign acc       = ioctl_wr && dl_ours;
  assign rise      = dl_ours && !dl_q;
  assign fall      = !dl_ours && dl_q;
  assign ending    = fin || fall;
  assign byte_addr = BASE_ADDR + ioctl_addr;
  assign word      = word_of(byte_addr);
  assign odd       = byte_addr[0];
  assign addr_p1   = ioctl_addr + 25'd1;
  assign flush_req = '{addr: pend_addr, din: {8'h00, pend_byte}, wtbt: WTBT_LO};

  assign mem_addr = req.addr;
  assign mem_din  = req.din;
  assign mem_wtbt = req.wtbt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      req        <= '0;
      q_req      <= '0;
      q_vld      <= 1'b0;
      pend       <= 1'b0;
      pend_byte  <= '0;
      pend_addr  <= '0;
      fin        <= 1'b0;
      dl_q       <= 1'b0;
      rom_size   <= '0;
      loaded     <= 1'b0;
      mem_we     <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      state      <= state_nx;
      req        <= req_nx;
      q_req      <= q_req_nx;
      q_vld      <= q_vld_nx;
      pend       <= pend_nx;
      pend_byte  <= pend_byte_nx;
      pend_addr  <= pend_addr_nx;
      fin        <= fin_nx;
      dl_q       <= dl_ours;
      rom_size   <= rom_size_nx;
      loaded     <= loaded_nx;
      mem_we     <= mem_we_nx;
      ioctl_wait <= wait_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    req_nx       = req;
    q_req_nx     = q_req;
    q_vld_nx     = q_vld;
    pend_nx      = pend;
    pend_byte_nx = pend_byte;
    pend_addr_nx = pend_addr;
    fin_nx       = fin || fall;
    rom_size_nx  = rom_size;
    loaded_nx    = loaded;

    if (acc && addr_p1 > rom_size) rom_size_nx = addr_p1;

    case (state)
      IDLE: begin
        if (acc) begin
          if (!odd) begin
            pend_nx      = 1'b1;
            pend_byte_nx = ioctl_dout;
            pend_addr_nx = word;
            state_nx     = COLLECT;
          end else begin
            req_nx   = '{addr: word, din: {ioctl_dout, 8'h00}, wtbt: WTBT_HI};
            state_nx = WRITE;
          end
        end else if (ending) begin
          state_nx = DONE;
        end
      end
      COLLECT: begin
        if (acc) begin
          state_nx = WRITE;
          if (odd && word == pend_addr) begin
            req_nx  = '{addr: pend_addr, din: {ioctl_dout, pend_byte}, wtbt: WTBT_BOTH};
            pend_nx = 1'b0;
          end else if (odd) begin
            // Stray odd byte: flush the orphan even byte, then queue the odd write.
            req_nx   = flush_req;
            pend_nx  = 1'b0;
            q_vld_nx = 1'b1;
            q_req_nx = '{addr: word, din: {ioctl_dout, 8'h00}, wtbt: WTBT_HI};
          end else begin
            req_nx       = flush_req;
            pend_byte_nx = ioctl_dout;
            pend_addr_nx = word;
          end
        end else if (ending) begin
          req_nx   = flush_req;
          pend_nx  = 1'b0;
          state_nx = FLUSH;
        end
      end
      WRITE, FLUSH: state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (mem_ready) begin
          if (q_vld) begin
            req_nx   = q_req;
            q_vld_nx = 1'b0;
            state_nx = WRITE;
          end else if (ending && pend) begin
            req_nx   = flush_req;
            pend_nx  = 1'b0;
            state_nx = FLUSH;
          end else if (ending) begin
            state_nx = DONE;
          end else begin
            state_nx = pend ? COLLECT : IDLE;
          end
        end
      end
      DONE:    ;
      default: state_nx = IDLE;
    endcase

    // HPS is stalled from a strobe-driven write until its completion; end-of-image flush does not stall.
    mem_we_nx = (state_nx == WRITE) || (state_nx == FLUSH);
    wait_nx   = (state_nx == WRITE) || (state_nx == WAIT_RDY && ioctl_wait);
    if (state_nx == DONE) loaded_nx = 1'b1;

    if (rise) begin
      state_nx    = IDLE;
      pend_nx     = 1'b0;
      q_vld_nx    = 1'b0;
      fin_nx      = 1'b0;
      rom_size_nx = '0;
      loaded_nx   = 1'b0;
      mem_we_nx   = 1'b0;
      wait_nx     = 1'b0;
    end
  end

`ifdef GNW_LOADER_CHECKSUM_EN
  gnw_cksum16 u_cksum (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (rise),
    .en      (acc && !rise),
    .data    (ioctl_dout),
    .sum     (cksum)
  );
`endif

  a_no_strobe_in_wait: assert property (@(posedge clk_sys) disable iff (reset) !(acc && ioctl_wait));
endmodule
